// File: rtl/game_tick_timer.sv
// Round/tick timer: turns the GameSpeed code into a periodic one-cycle Tick and
// counts the round down in seconds, flagging Timeout when it reaches zero.
module game_tick_timer #(
  parameter int BASE_PERIOD = 50000000,
  parameter int SEC_CYCLES  = 50000000,
  parameter int ROUND_SEC   = 60,
  parameter int TIME_W      = 7
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Pause,
  input  logic [1:0]        GameSpeed,
  output logic              Tick,
  output logic [TIME_W-1:0] TimeLeft,
  output logic              Running,
  output logic              Timeout
);

  localparam int TICK_W = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
  localparam int SEC_W  = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;

  localparam logic [TICK_W-1:0] LIM0     = TICK_W'(BASE_PERIOD - 1);
  localparam logic [TICK_W-1:0] LIM1     = TICK_W'(BASE_PERIOD / 2 - 1);
  localparam logic [TICK_W-1:0] LIM2     = TICK_W'(BASE_PERIOD / 4 - 1);
  localparam logic [TICK_W-1:0] LIM3     = TICK_W'(BASE_PERIOD / 8 - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST = SEC_W'(SEC_CYCLES - 1);
  localparam logic [TIME_W-1:0] ROUND_LD = TIME_W'(ROUND_SEC);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_TIMEOUT} state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SEC_W-1:0]    sec_cnt_q, sec_cnt_d;
  logic [1:0]          speed_q, speed_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic                tick_q, tick_d;
  logic                running_q, timeout_q;
  logic [TICK_W-1:0]   limit;

  // The period limit follows the latched speed, so mid-period GameSpeed
  // changes cannot shorten the period already in progress.
  always_comb begin
    case (speed_q)
      2'b00:   limit = LIM0;
      2'b01:   limit = LIM1;
      2'b10:   limit = LIM2;
      default: limit = LIM3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    sec_cnt_d  = sec_cnt_q;
    speed_d    = speed_q;
    time_d     = time_q;
    tick_d     = 1'b0;
    if (Start) begin
      state_d    = S_RUN;
      tick_cnt_d = '0;
      sec_cnt_d  = '0;
      speed_d    = GameSpeed;
      time_d     = ROUND_LD;
    end else begin
      case (state_q)
        S_RUN, S_PAUSED: begin
          if (Pause) begin
            state_d = S_PAUSED;
          end else begin
            // Leaving PAUSED counts on the same edge, so a pause costs
            // exactly the number of cycles Pause was held.
            state_d = S_RUN;
            if (tick_cnt_q == limit) begin
              tick_cnt_d = '0;
              tick_d     = 1'b1;
              speed_d    = GameSpeed;
            end else begin
              tick_cnt_d = tick_cnt_q + 1'b1;
            end
            if (sec_cnt_q == SEC_LAST) begin
              sec_cnt_d = '0;
              time_d    = time_q - 1'b1;
              if (time_q == TIME_W'(1)) begin
                state_d = S_TIMEOUT;
                tick_d  = 1'b0;
              end
            end else begin
              sec_cnt_d = sec_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      sec_cnt_q  <= '0;
      speed_q    <= 2'b00;
      time_q     <= '0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      sec_cnt_q  <= sec_cnt_d;
      speed_q    <= speed_d;
      time_q     <= time_d;
      tick_q     <= tick_d;
      running_q  <= (state_d == S_RUN);
      timeout_q  <= (state_d == S_TIMEOUT);
    end
  end

  assign Tick     = tick_q;
  assign TimeLeft = time_q;
  assign Running  = running_q;
  assign Timeout  = timeout_q;

endmodule

// File: tb/tb_game_tick_timer.sv
// Bench for game_tick_timer: vector table, directed round scenarios and random
// stimulus compared every cycle against an elapsed-time reference model.
module tb_game_tick_timer;

  localparam int BP = 16;
  localparam int SC = 40;
  localparam int RS = 3;
  localparam int TW = 7;

  logic          Clock = 1'b0;
  logic          Reset, Start, Pause;
  logic [1:0]    GameSpeed;
  logic          Tick;
  logic [TW-1:0] TimeLeft;
  logic          Running, Timeout;

  always #5 Clock = ~Clock;

  game_tick_timer #(
    .BASE_PERIOD(BP), .SEC_CYCLES(SC), .ROUND_SEC(RS), .TIME_W(TW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Pause(Pause),
    .GameSpeed(GameSpeed), .Tick(Tick), .TimeLeft(TimeLeft),
    .Running(Running), .Timeout(Timeout)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a round is described by total active cycles elapsed and
  // cycles since the last tick boundary; outputs follow arithmetically.
  bit m_round, m_paused, m_done, m_tick;
  int m_elapsed, m_phase, m_period;

  function automatic int m_timeleft();
    if (m_round) return RS - m_elapsed / SC;
    return 0;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit p, input bit [1:0] g);
    if (!r) begin
      m_round = 0; m_paused = 0; m_done = 0; m_tick = 0;
      m_elapsed = 0; m_phase = 0; m_period = BP;
    end else if (s) begin
      m_round = 1; m_paused = 0; m_done = 0; m_tick = 0;
      m_elapsed = 0; m_phase = 0; m_period = BP >> g;
    end else if (m_round && p) begin
      m_paused = 1; m_tick = 0;
    end else if (m_round) begin
      m_paused = 0; m_tick = 0;
      m_elapsed++; m_phase++;
      if (m_phase == m_period) begin
        m_tick = 1; m_phase = 0; m_period = BP >> g;
      end
      if (m_elapsed == RS * SC) begin
        m_round = 0; m_done = 1; m_tick = 0;
      end
    end else begin
      m_tick = 0;
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit r, input bit s, input bit p, input bit [1:0] g);
    Reset = r; Start = s; Pause = p; GameSpeed = g;
    model_step(r, s, p, g);
    @(posedge Clock);
    #1;
    chk1("model_tick", Tick, m_tick);
    chkv("model_timeleft", 32'(TimeLeft), 32'(m_timeleft()));
    chk1("model_running", Running, m_round && !m_paused);
    chk1("model_timeout", Timeout, m_done);
  endtask

  typedef struct {
    bit r, s, p;
    bit [1:0] g;
    bit tick;
    int tl;
    bit run, to;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit s, input bit p, input bit [1:0] g,
                              input bit tick, input int tl, input bit run, input bit to);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.g = g; v.tick = tick; v.tl = tl; v.run = run; v.to = to;
    return v;
  endfunction

  vec_t vt[14];
  int   first_tick, n_ticks, tl2_at, tl1_at, to_at, late_ticks;
  int   pause_ticks, pause_tl_chg, pause_tl, bad_after_rst;
  int   tk[$];
  int   exp_tk[5];
  bit   pz;

  initial begin
    // Table: reset dominance, fast ticks, Start beating Pause, pause/resume.
    vt[0]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    vt[1]  = mk(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 0, 1'b0, 1'b0);
    vt[2]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    vt[3]  = mk(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 3, 1'b1, 1'b0);
    vt[4]  = mk(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 3, 1'b1, 1'b0);
    vt[5]  = mk(1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 3, 1'b1, 1'b0);
    vt[6]  = mk(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 3, 1'b1, 1'b0);
    vt[7]  = mk(1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 3, 1'b1, 1'b0);
    vt[8]  = mk(1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 3, 1'b1, 1'b0);
    vt[9]  = mk(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 3, 1'b0, 1'b0);
    vt[10] = mk(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 3, 1'b0, 1'b0);
    vt[11] = mk(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 3, 1'b1, 1'b0);
    vt[12] = mk(1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 3, 1'b1, 1'b0);
    vt[13] = mk(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].r, vt[i].s, vt[i].p, vt[i].g);
      chk1($sformatf("vec%0d_tick", i), Tick, vt[i].tick);
      chkv($sformatf("vec%0d_timeleft", i), 32'(TimeLeft), 32'(vt[i].tl));
      chk1($sformatf("vec%0d_running", i), Running, vt[i].run);
      chk1($sformatf("vec%0d_timeout", i), Timeout, vt[i].to);
    end

    // Reset then 50 idle cycles: no Tick.
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    n_ticks = 0;
    for (int k = 0; k < 50; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'd0);
      if (Tick) n_ticks++;
    end
    chkv("idle_ticks", 32'(n_ticks), 32'd0);

    // Full round at slowest speed.
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    first_tick = -1; n_ticks = 0; tl2_at = -1; tl1_at = -1; to_at = -1; late_ticks = 0;
    for (int k = 1; k <= 150; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'd0);
      if (Tick) begin
        n_ticks++;
        if (first_tick < 0) first_tick = k;
        if (to_at >= 0) late_ticks++;
      end
      if (TimeLeft == 2 && tl2_at < 0) tl2_at = k;
      if (TimeLeft == 1 && tl1_at < 0) tl1_at = k;
      if (Timeout && to_at < 0) begin
        to_at = k;
        chkv("round_end_timeleft", 32'(TimeLeft), 32'd0);
        chk1("round_end_running", Running, 1'b0);
      end
    end
    chkv("round_first_tick", 32'(first_tick), 32'd16);
    chkv("round_tick_count", 32'(n_ticks), 32'd7);
    chkv("round_tl2_cycle", 32'(tl2_at), 32'd40);
    chkv("round_tl1_cycle", 32'(tl1_at), 32'd80);
    chkv("round_timeout_cycle", 32'(to_at), 32'd120);
    chkv("round_ticks_after_timeout", 32'(late_ticks), 32'd0);

    // Fastest speed, switch to slowest mid-period: boundary at 6 then 16 apart.
    cyc(1'b1, 1'b1, 1'b0, 2'd3);
    tk.delete();
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b1, 1'b0, 1'b0, (k < 5) ? 2'd3 : 2'd0);
      if (Tick) tk.push_back(k);
    end
    exp_tk[0] = 2; exp_tk[1] = 4; exp_tk[2] = 6; exp_tk[3] = 22; exp_tk[4] = 38;
    chkv("speed_tick_count", 32'(tk.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chkv($sformatf("speed_tick%0d_cycle", i), 32'((i < tk.size()) ? tk[i] : -1), 32'(exp_tk[i]));

    // Pause for 25 cycles mid-round: Timeout moves from 120 to 145.
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    pause_ticks = 0; pause_tl_chg = 0; pause_tl = -1; to_at = -1;
    for (int k = 1; k <= 160; k++) begin
      pz = (k >= 51 && k <= 75);
      cyc(1'b1, 1'b0, pz, 2'd0);
      if (pz) begin
        if (Tick) pause_ticks++;
        if (pause_tl < 0) pause_tl = int'(TimeLeft);
        else if (int'(TimeLeft) != pause_tl) pause_tl_chg++;
      end
      if (Timeout && to_at < 0) to_at = k;
    end
    chkv("pause_ticks", 32'(pause_ticks), 32'd0);
    chkv("pause_timeleft", 32'(pause_tl), 32'd2);
    chkv("pause_timeleft_changes", 32'(pause_tl_chg), 32'd0);
    chkv("pause_timeout_cycle", 32'(to_at), 32'd145);

    // Restart from TIMEOUT, then restart from RUN with one second left.
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    chkv("restart_to_timeleft", 32'(TimeLeft), 32'd3);
    chk1("restart_to_timeout", Timeout, 1'b0);
    chk1("restart_to_running", Running, 1'b1);
    first_tick = -1;
    for (int k = 1; k <= 85; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'd0);
      if (Tick && first_tick < 0) first_tick = k;
    end
    chkv("restart_to_first_tick", 32'(first_tick), 32'd16);
    chkv("late_round_timeleft", 32'(TimeLeft), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    chkv("restart_run_timeleft", 32'(TimeLeft), 32'd3);
    first_tick = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'd0);
      if (Tick && first_tick < 0) first_tick = k;
    end
    chkv("restart_run_first_tick", 32'(first_tick), 32'd16);

    // Reset while PAUSED, then stay quiet until the next Start.
    cyc(1'b1, 1'b1, 1'b0, 2'd1);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 1'b0, 2'd1);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b1, 2'd1);
    chk1("paused_before_reset", Running, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 2'd1);
    chk1("rst_tick", Tick, 1'b0);
    chkv("rst_timeleft", 32'(TimeLeft), 32'd0);
    chk1("rst_running", Running, 1'b0);
    chk1("rst_timeout", Timeout, 1'b0);
    bad_after_rst = 0;
    for (int k = 0; k < 30; k++) begin
      cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      if (Tick || Running || Timeout) bad_after_rst++;
    end
    chkv("post_reset_quiet", 32'(bad_after_rst), 32'd0);

    // Random traffic against the model.
    pz = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) pz = ~pz;
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 149) == 0), pz,
          2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/game_tick_timer.md
Name: game_tick_timer

Overview:
- Consumer of the 2-bit GameSpeed code from the speed-selection logic.
- Converts the code into a periodic one-cycle Tick pulse that advances game objects.
- Runs an independent round countdown in seconds and flags Timeout at zero.
- Sits between the speed-select block and the game-logic/display blocks.

Parameters:
- BASE_PERIOD, 50000000: Clock cycles between Ticks at GameSpeed 00. Must be a multiple of 8.
- SEC_CYCLES, 50000000: Clock cycles per round second.
- ROUND_SEC, 60: Round length in seconds, loaded on Start. Range 1..2^TIME_W-1.
- TIME_W, 7: Width of TimeLeft.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-low; clock Clock
- Start  in  1  single-cycle pulse; begins or restarts a round
- Pause  in  1  level; high freezes the round
- GameSpeed  in  2  speed code: 00 slowest .. 11 fastest
- Tick  out  1  one-cycle game-advance pulse
- TimeLeft  out  TIME_W  seconds remaining in round
- Running  out  1  high in RUN state only
- Timeout  out  1  high in TIMEOUT state only

Behaviour:
- States: IDLE, RUN, PAUSED, TIMEOUT. All outputs are registered.
- Reset (Reset==0 at a Clock edge): state IDLE, Tick=0, TimeLeft=0, Running=0, Timeout=0, tick_cnt=0, sec_cnt=0, SpeedReg=00. Reset overrides every other input, including mid-round.
- Tick period limit: L = (BASE_PERIOD >> SpeedReg) - 1, giving periods P, P/2, P/4 and P/8 cycles.
- Start (any state): TimeLeft<=ROUND_SEC, tick_cnt<=0, sec_cnt<=0, SpeedReg<=GameSpeed, state<=RUN, Tick<=0.
  - Start has priority over Pause in the same cycle.
  - Pause is evaluated from the next cycle.
- RUN, Pause==0, no Start:
  - tick_cnt increments. When tick_cnt==L: tick_cnt<=0, Tick<=1 for the next cycle, SpeedReg<=GameSpeed. Otherwise Tick<=0.
  - sec_cnt increments. When sec_cnt==SEC_CYCLES-1: sec_cnt<=0, TimeLeft<=TimeLeft-1.
- Speed changes take effect only at a Tick boundary. Mid-period changes of GameSpeed never shorten or glitch the current period.
- First Tick after Start arrives L+1 cycles after the Start edge. Tick is visible in the cycle following that edge.
- RUN with Pause==1: state<=PAUSED on that edge. tick_cnt and sec_cnt hold, no Tick, TimeLeft holds.
- PAUSED: counters hold, Tick=0. When Pause==0, state<=RUN and counting resumes from the held values, with no extra or lost cycles.
- Round end: when the seconds boundary occurs with TimeLeft==1:
  - TimeLeft<=0, state<=TIMEOUT, Timeout<=1.
  - A Tick coinciding with that edge is suppressed (Tick<=0).
- TIMEOUT: Tick=0, counters frozen, TimeLeft=0. Only Start or Reset exits.
- IDLE: no Tick, counters hold at 0. Pause is ignored in IDLE and TIMEOUT.
- Running = (state==RUN). Timeout = (state==TIMEOUT). Both are registered alongside the state.
- Width rules:
  - tick_cnt is sized for BASE_PERIOD-1; sec_cnt is sized for SEC_CYCLES-1.
  - TimeLeft never underflows.

Test Plan:
- Params BASE_PERIOD=16, SEC_CYCLES=40, ROUND_SEC=3. Reset low 2 cycles -> all outputs 0, state IDLE. Reset high, no Start for 50 cycles -> Tick never asserts.
- GameSpeed=00, Start pulse -> Tick pulses every 16 cycles, first 16 cycles after Start. TimeLeft 3→2→1 at 40-cycle intervals. At cycle 120: TimeLeft=0, Timeout=1, Running=0, no further Ticks.
- GameSpeed=11 at Start -> Tick every 2 cycles. Switch GameSpeed to 00 mid-period -> one more 2-cycle period completes, then 16-cycle spacing.
- Pause high for 25 cycles mid-round -> no Ticks and TimeLeft frozen during the pause. After release, Timeout is delayed by exactly 25 cycles vs. the unpaused run.
- Start pulse while TIMEOUT, and again while RUN with TimeLeft=1 -> TimeLeft reloads to 3, counters restart, first Tick L+1 cycles later. Start and Pause high together -> RUN for one cycle, then PAUSED.
- Reset low mid-round while PAUSED -> next cycle all outputs 0, state IDLE. Tick, Timeout and Running stay 0 until the next Start.
